// File: rtl/dmem_bank_pkg.sv
// Shared definitions for dmem_bank: latency bounds, byte-lane width and the
// clear-sweep state encodings (used only when MEM_CLEAR_EN is defined).
package dmem_bank_pkg;
  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 4;
  localparam int LANE_W       = 8;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/dmem_resp_pipe.sv
// Response latency pipeline: LAT-deep shift register of {valid, err, rdata},
// asynchronously cleared so reset drops anything in flight.
module dmem_resp_pipe #(
  parameter int W   = 18,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] stg [LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) stg[i] <= '0;
    end else begin
      stg[0] <= d;
      for (int i = 1; i < LAT; i++) stg[i] <= stg[i-1];
    end
  end

  assign q = stg[LAT-1];
endmodule

// File: rtl/dmem_bank.sv
// Single-port data memory with valid/ready requests, byte-lane writes and a
// registered response pipeline. Define MEM_CLEAR_EN to zero the array after reset.
module dmem_bank
  import dmem_bank_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int DEPTH    = 256,
  parameter int READ_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  input  logic [DATA_W/8-1:0]    req_be,
  output logic                   resp_valid,
  output logic [DATA_W-1:0]      resp_rdata,
  output logic                   resp_err
);
  localparam int NB    = DATA_W / LANE_W;
  localparam int IDX_W = idx_width(DEPTH);

  if (READ_LAT < READ_LAT_MIN || READ_LAT > READ_LAT_MAX) begin : g_bad_lat
    $error("dmem_bank: READ_LAT out of range");
  end
  if (DATA_W % LANE_W != 0) begin : g_bad_width
    $error("dmem_bank: DATA_W must be a multiple of 8");
  end
  if (DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
    $error("dmem_bank: DEPTH exceeds address space");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  idx;
  logic              addr_err;
  logic              accept;
  logic              do_write;

  assign idx      = req_addr[IDX_W-1:0];
  // Widened compare so DEPTH == 2**ADDR_W never flags and addresses never wrap.
  assign addr_err = {1'b0, req_addr} >= (ADDR_W+1)'(DEPTH);
  assign accept   = req_valid & req_ready;
  assign do_write = accept & req_we & ~addr_err;

`ifdef MEM_CLEAR_EN
  logic [0:0]       state;
  logic [IDX_W-1:0] clr_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else if (state == ST_CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == IDX_W'(DEPTH - 1)) state <= ST_READY;
    end
  end

  assign req_ready = (state == ST_READY);

  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (do_write) begin
      for (int i = 0; i < NB; i++)
        if (req_be[i]) mem[idx][i*LANE_W +: LANE_W] <= req_wdata[i*LANE_W +: LANE_W];
    end
  end
`else
  assign req_ready = 1'b1;

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < NB; i++)
        if (req_be[i]) mem[idx][i*LANE_W +: LANE_W] <= req_wdata[i*LANE_W +: LANE_W];
    end
  end
`endif

  logic [DATA_W+1:0] pipe_d;
  logic [DATA_W+1:0] pipe_q;
  logic [DATA_W-1:0] rd_word;

  // Writes and errors return zero data; the array is only sampled for good reads.
  assign rd_word = (accept && !req_we && !addr_err) ? mem[idx] : '0;
  assign pipe_d  = {accept, accept & addr_err, rd_word};

  dmem_resp_pipe #(
    .W   (DATA_W + 2),
    .LAT (READ_LAT)
  ) u_resp_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pipe_d),
    .q     (pipe_q)
  );

  assign {resp_valid, resp_err, resp_rdata} = pipe_q;
endmodule

// File: tb/tb_dmem_bank.sv
// Scoreboard bench for dmem_bank: two instances (READ_LAT=1 and 3) share stimulus;
// responses are predicted from a word-array model and checked by a negedge monitor.
module tb_dmem_bank;
  localparam int DEPTH = 256;
  localparam int LAT0  = 1;
  localparam int LAT1  = 3;

  typedef struct {
    logic        err;
    logic [15:0] rdata;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [1:0]  req_be = '0;

  logic        rdy [2];
  logic        rv  [2];
  logic        re  [2];
  logic [15:0] rd  [2];

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t q [2][$];
  logic [15:0] model_mem [DEPTH];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_bank #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .READ_LAT(LAT0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[0]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(rv[0]), .resp_rdata(rd[0]), .resp_err(re[0]));

  dmem_bank #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .READ_LAT(LAT1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[1]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(rv[1]), .resp_rdata(rd[1]), .resp_err(re[1]));

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endfunction

  // Monitor: pops expected responses when the DUT presents one; idle cycles must be all-zero.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rv[k]) begin
        if (q[k].size() == 0) begin
          chk($sformatf("dut%0d_unexpected_resp", k), 32'(rv[k]), 32'd0);
        end else begin
          exp_t e;
          e = q[k].pop_front();
          chk($sformatf("dut%0d_resp_cycle", k), 32'(cyc), 32'(e.due));
          chk($sformatf("dut%0d_resp_err", k), 32'(re[k]), 32'(e.err));
          chk($sformatf("dut%0d_resp_rdata", k), 32'(rd[k]), 32'(e.rdata));
        end
      end else begin
        chk($sformatf("dut%0d_idle_outputs", k), {15'd0, re[k], rd[k]}, 32'd0);
        if (q[k].size() > 0 && q[k][0].due <= cyc) begin
          exp_t e;
          e = q[k].pop_front();
          chk($sformatf("dut%0d_missing_resp", k), 32'(rv[k]), 32'd1);
        end
      end
    end
  end

  // Reference behaviour: one request at a time against a plain word array.
  task automatic send(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                      input logic [1:0] be);
    int   guard;
    exp_t e;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
    guard = 0;
    while (!(rdy[0] && rdy[1]) && guard < 1000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 1000) begin
      chk("ready_timeout", 32'(rdy[0] && rdy[1]), 32'd1);
      req_valid = 1'b0;
      return;
    end
    e.err   = (int'(addr) >= DEPTH);
    e.rdata = (we || e.err) ? 16'h0000 : model_mem[addr];
    if (we && !e.err)
      for (int b = 0; b < 2; b++)
        if (be[b]) model_mem[addr][b*8 +: 8] = wd[b*8 +: 8];
    e.due = cyc + LAT0; q[0].push_back(e);
    e.due = cyc + LAT1; q[1].push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q[0].delete();
    q[1].delete();
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
`ifdef MEM_CLEAR_EN
    begin
      int n;
      n = 1;
      while (!rdy[0] && n < DEPTH + 20) begin @(posedge clk); #1; n++; end
      chk("clear_sweep_len", 32'(n), 32'(DEPTH));
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 16'h0000;
    end
`endif
  endtask

  initial begin
    #1 rst_n = 1'b0;
    do_reset();

    for (int i = 0; i < DEPTH; i++) send(1'b1, 16'(i), 16'($urandom), 2'b11);
    idle(4);

    send(1'b1, 16'h0005, 16'hBEEF, 2'b11);
    send(1'b0, 16'h0005, 16'h0000, 2'b00);
    idle(4);

    send(1'b1, 16'h0010, 16'h1234, 2'b11);
    send(1'b1, 16'h0010, 16'hAB55, 2'b01);
    send(1'b0, 16'h0010, 16'h0000, 2'b00);
    send(1'b1, 16'h0010, 16'hCD00, 2'b10);
    send(1'b1, 16'h0010, 16'h9999, 2'b00);
    send(1'b0, 16'h0010, 16'h0000, 2'b00);
    idle(4);

    send(1'b1, 16'h0100, 16'hFFFF, 2'b11);
    send(1'b0, 16'h0100, 16'h0000, 2'b00);
    send(1'b0, 16'h0000, 16'h0000, 2'b00);
    send(1'b1, 16'hFFFF, 16'h1111, 2'b11);
    send(1'b0, 16'h00FF, 16'h0000, 2'b00);
    idle(4);

    send(1'b0, 16'h0001, 16'h0000, 2'b00);
    send(1'b0, 16'h0002, 16'h0000, 2'b00);
    send(1'b0, 16'h0003, 16'h0000, 2'b00);
    idle(5);

    send(1'b0, 16'h0001, 16'h0000, 2'b00);
    @(negedge clk);
    #1 do_reset();
    idle(5);

    for (int i = 0; i < 400; i++) begin
      logic        we;
      logic [15:0] addr;
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      we   = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(DEPTH, 65535))
                                         : 16'($urandom_range(0, DEPTH - 1));
      send(we, addr, 16'($urandom), 2'($urandom_range(0, 3)));
    end
    send(1'b0, 16'h0010, 16'h0000, 2'b00);
    idle(10);

    chk("dut0_queue_drained", 32'(q[0].size()), 32'd0);
    chk("dut1_queue_drained", 32'(q[1].size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
